regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the pipelined RISC-V core; successor to the single-write, combinational-read register file.
- Configurable read and write port counts, with same-cycle write-to-read bypass and a per-register busy scoreboard that flags RAW hazards to decode.
- x0 hardwired to zero; x2 (sp) loaded from the stack pointer input on reset; a0..a7 exported for the ecall path.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
REGISTER_WIDTH, 64, data width of each register
REGISTERNO_WIDTH, 5, register index width; the file holds 2**REGISTERNO_WIDTH registers
NUM_READ, 2, number of read ports
NUM_WRITE, 2, number of writeback ports
SP_REGNO, 2, index of the register loaded from in_stackptr at reset

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
in_stackptr  in  REGISTER_WIDTH  sp reset value
in_rd_regno  in  NUM_READ x REGISTERNO_WIDTH  read addresses
out_rd_value  out  NUM_READ x REGISTER_WIDTH  read data, combinational
out_rd_busy  out  NUM_READ  addressed register has an outstanding producer
out_hazard  out  1  OR of out_rd_busy over all read ports
in_issue_valid  in  1  decode issues an instruction that writes in_issue_regno
in_issue_regno  in  REGISTERNO_WIDTH  destination register being issued
in_wr_enable  in  NUM_WRITE  per-port write strobe
in_wr_regno  in  NUM_WRITE x REGISTERNO_WIDTH  write destinations
in_wr_value  in  NUM_WRITE x REGISTER_WIDTH  write data
out_busy_count  out  REGISTERNO_WIDTH+1  number of busy registers
out_args  out  8 x REGISTER_WIDTH  registers x10..x17 (a0..a7)

Behaviour:
Reset
- Synchronous, active-high: every register clears to 0 except SP_REGNO, which loads in_stackptr.
- All busy bits clear; out_busy_count = 0.
- Reset overrides any issue or write in the same cycle.
- Reset asserted mid-stream discards all pending scoreboard state.

Reads
- Purely combinational, zero latency.
- out_rd_value for port r, in priority order:
  - address 0 -> 0;
  - else, if any write port w has in_wr_enable[w] and in_wr_regno[w] == address, the highest-index matching w's in_wr_value (bypass);
  - else the array content.
- out_rd_busy[r] = busy[address] after the same-cycle writeback clear, but before the same-cycle issue set. Address 0 is never busy.

Writes
- On posedge, when not in reset, each enabled port with regno != 0 writes its register.
- Two ports targeting the same regno: the higher index wins.
- Writes to x0 are dropped.
- Written data is visible in the array the next cycle and via bypass in the same cycle.

Scoreboard
- Per-register busy bit.
- Set on posedge when in_issue_valid and in_issue_regno != 0.
- Cleared on posedge when any enabled write port targets that register.
- Set and clear on the same register in the same cycle: set wins (new producer outstanding).
- Issuing to an already-busy register keeps it busy; there is no counting per register.
- A write to a non-busy register is legal: it updates data and leaves busy at 0.

out_busy_count
- Registered popcount of the busy bits; updates with the busy vector and equals its popcount every cycle.

out_args
- Direct array read of x10..x17, without bypass.

Decomposition:
- regfile_pkg holds:
  - typedef regno_t (REGISTERNO_WIDTH bits) and data_t;
  - constants REG_ZERO = 0, REG_SP = 2, REG_A0 = 10, NUM_ARGS = 8;
  - a function that resolves the write-port priority match.
- One sub-module, regfile_bypass_mux: a per-read-port bypass/priority selector instantiated NUM_READ times.
- Array and scoreboard stay in the top module.

Test Plan:
- Reset with in_stackptr = 0x8000_0000 -> next cycle reading x2 returns 0x8000_0000; every other register returns 0; out_busy_count = 0; out_hazard = 0.
- Write port 0 writes x5 = 42 while read port 1 reads x5 in the same cycle -> out_rd_value[1] = 42 (bypass). The following cycle, with no write, x5 still reads 42.
- Both write ports target x7 (port 0 = 1, port 1 = 2) -> read x7 returns 2 the same cycle and after; a write of 99 to x0 -> x0 reads 0.
- Issue x9; next cycle read x9 -> out_rd_busy = 1, out_hazard = 1, out_busy_count = 1. Writeback x9 = 7 -> same cycle busy reads 0 and data reads 7; next cycle out_busy_count = 0.
- Issue x9 and writeback x9 in the same cycle -> x9 remains busy, holds the written value, and out_busy_count is unchanged at 1.
- Issue x3, x4, x6 in successive cycles, then assert reset -> the cycle after reset all busy bits are 0, out_busy_count = 0, and a0..a7 = 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, register-index constants and write-port priority helper.
// Rev 1.0
`default_nettype none

package regfile_pkg;

  localparam int DEF_REGISTER_WIDTH   = 64;
  localparam int DEF_REGISTERNO_WIDTH = 5;

  typedef logic [DEF_REGISTERNO_WIDTH-1:0] regno_t;
  typedef logic [DEF_REGISTER_WIDTH-1:0]   data_t;

  localparam int REG_ZERO  = 0;
  localparam int REG_SP    = 2;
  localparam int REG_A0    = 10;
  localparam int NUM_ARGS  = 8;
  localparam int MAX_WRITE = 16;

  // Keeps only the highest-index set bit: the last write port in order wins.
  function automatic logic [MAX_WRITE-1:0] highest_match(input logic [MAX_WRITE-1:0] hits);
    logic [MAX_WRITE-1:0] sel;
    sel = '0;
    for (int i = 0; i < MAX_WRITE; i++) begin
      if (hits[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback bus into the register file.
// Rev 1.0
`default_nettype none

interface regfile_scoreboard_if #(
  parameter int REGISTER_WIDTH   = 64,
  parameter int REGISTERNO_WIDTH = 5,
  parameter int NUM_READ         = 2,
  parameter int NUM_WRITE        = 2
);
  import regfile_pkg::*;

  logic [REGISTER_WIDTH-1:0]                       in_stackptr;
  logic [NUM_READ-1:0][REGISTERNO_WIDTH-1:0]       in_rd_regno;
  logic [NUM_READ-1:0][REGISTER_WIDTH-1:0]         out_rd_value;
  logic [NUM_READ-1:0]                             out_rd_busy;
  logic                                            out_hazard;
  logic                                            in_issue_valid;
  logic [REGISTERNO_WIDTH-1:0]                     in_issue_regno;
  logic [NUM_WRITE-1:0]                            in_wr_enable;
  logic [NUM_WRITE-1:0][REGISTERNO_WIDTH-1:0]      in_wr_regno;
  logic [NUM_WRITE-1:0][REGISTER_WIDTH-1:0]        in_wr_value;
  logic [REGISTERNO_WIDTH:0]                       out_busy_count;
  logic [NUM_ARGS-1:0][REGISTER_WIDTH-1:0]         out_args;

  modport master (
    output in_stackptr, in_rd_regno, in_issue_valid, in_issue_regno,
           in_wr_enable, in_wr_regno, in_wr_value,
    input  out_rd_value, out_rd_busy, out_hazard, out_busy_count, out_args
  );

  modport slave (
    input  in_stackptr, in_rd_regno, in_issue_valid, in_issue_regno,
           in_wr_enable, in_wr_regno, in_wr_value,
    output out_rd_value, out_rd_busy, out_hazard, out_busy_count, out_args
  );

endinterface

`default_nettype wire

// File: rtl/regfile_bypass_mux.sv
// regfile_bypass_mux: one read port's x0 / write-bypass / array selection.
// Rev 1.0
`default_nettype none

module regfile_bypass_mux #(
  parameter int REGISTER_WIDTH   = 64,
  parameter int REGISTERNO_WIDTH = 5,
  parameter int NUM_WRITE        = 2
) (
  input  logic [REGISTERNO_WIDTH-1:0]                  rd_regno_i,
  input  logic [REGISTER_WIDTH-1:0]                    arr_value_i,
  input  logic [NUM_WRITE-1:0]                         wr_enable_i,
  input  logic [NUM_WRITE-1:0][REGISTERNO_WIDTH-1:0]   wr_regno_i,
  input  logic [NUM_WRITE-1:0][REGISTER_WIDTH-1:0]     wr_value_i,
  output logic [REGISTER_WIDTH-1:0]                    rd_value_o
);
  import regfile_pkg::*;

  logic [MAX_WRITE-1:0]      w_hits;
  logic [MAX_WRITE-1:0]      w_sel;
  logic [REGISTER_WIDTH-1:0] w_bypass;

  always_comb begin
    w_hits = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      w_hits[w] = wr_enable_i[w] && (wr_regno_i[w] == rd_regno_i);
    end
    w_sel    = highest_match(w_hits);
    w_bypass = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (w_sel[w]) begin
        w_bypass = wr_value_i[w];
      end
    end
    if (rd_regno_i == REGISTERNO_WIDTH'(REG_ZERO)) begin
      rd_value_o = '0;
    end else if (|w_hits) begin
      rd_value_o = w_bypass;
    end else begin
      rd_value_o = arr_value_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port integer register file with bypass and RAW busy scoreboard.
// Rev 1.0
`default_nettype none

module regfile_scoreboard #(
  parameter int REGISTER_WIDTH   = 64,
  parameter int REGISTERNO_WIDTH = 5,
  parameter int NUM_READ         = 2,
  parameter int NUM_WRITE        = 2,
  parameter int SP_REGNO         = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);
  import regfile_pkg::*;

  localparam int NUM_REGS = 1 << REGISTERNO_WIDTH;
  localparam logic [REGISTERNO_WIDTH-1:0] ZERO_IDX = REGISTERNO_WIDTH'(REG_ZERO);

  logic [NUM_REGS-1:0][REGISTER_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0][REGISTER_WIDTH-1:0] regs_d;
  logic [NUM_REGS-1:0]                     busy_q;
  logic [NUM_REGS-1:0]                     busy_d;
  logic [NUM_REGS-1:0]                     w_wr_hit;
  logic [NUM_REGS-1:0]                     w_issue_set;
  logic [NUM_REGS-1:0]                     w_busy_cleared;
  logic [REGISTERNO_WIDTH:0]               busy_count_q;
  logic [REGISTERNO_WIDTH:0]               busy_count_d;

  // Ascending port order makes the highest-index port win on a shared regno.
  always_comb begin
    regs_d   = regs_q;
    w_wr_hit = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (bus.in_wr_enable[w] && (bus.in_wr_regno[w] != ZERO_IDX)) begin
        regs_d[bus.in_wr_regno[w]]   = bus.in_wr_value[w];
        w_wr_hit[bus.in_wr_regno[w]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_issue_set = '0;
    if (bus.in_issue_valid && (bus.in_issue_regno != ZERO_IDX)) begin
      w_issue_set[bus.in_issue_regno] = 1'b1;
    end
  end

  // Clear first, then set: a same-cycle issue leaves a new producer outstanding.
  assign w_busy_cleared = busy_q & ~w_wr_hit;
  assign busy_d         = w_busy_cleared | w_issue_set;

  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_count_d = busy_count_d + {{REGISTERNO_WIDTH{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q           <= '0;
      regs_q[SP_REGNO] <= bus.in_stackptr;
      busy_q           <= '0;
      busy_count_q     <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  generate
    for (genvar r = 0; r < NUM_READ; r++) begin : g_read
      regfile_bypass_mux #(
        .REGISTER_WIDTH   (REGISTER_WIDTH),
        .REGISTERNO_WIDTH (REGISTERNO_WIDTH),
        .NUM_WRITE        (NUM_WRITE)
      ) u_mux (
        .rd_regno_i  (bus.in_rd_regno[r]),
        .arr_value_i (regs_q[bus.in_rd_regno[r]]),
        .wr_enable_i (bus.in_wr_enable),
        .wr_regno_i  (bus.in_wr_regno),
        .wr_value_i  (bus.in_wr_value),
        .rd_value_o  (bus.out_rd_value[r])
      );

      assign bus.out_rd_busy[r] = (bus.in_rd_regno[r] != ZERO_IDX) &&
                                  w_busy_cleared[bus.in_rd_regno[r]];
    end

    for (genvar a = 0; a < NUM_ARGS; a++) begin : g_args
      assign bus.out_args[a] = regs_q[REG_A0 + a];
    end
  endgenerate

  assign bus.out_hazard     = |bus.out_rd_busy;
  assign bus.out_busy_count = busy_count_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of reads, bypass, write priority and scoreboard.
// Rev 1.0
`default_nettype none

module tb_regfile_scoreboard;

  localparam logic [63:0] SP_INIT = 64'h0000_0000_8000_0000;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  regfile_scoreboard_if #(
    .REGISTER_WIDTH(64), .REGISTERNO_WIDTH(5), .NUM_READ(2), .NUM_WRITE(2)
  ) bus ();

  regfile_scoreboard #(
    .REGISTER_WIDTH(64), .REGISTERNO_WIDTH(5), .NUM_READ(2), .NUM_WRITE(2), .SP_REGNO(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_issue_valid = 1'b0;
    bus.in_issue_regno = '0;
    bus.in_wr_enable   = '0;
    bus.in_wr_regno    = '0;
    bus.in_wr_value    = '0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    bus.in_stackptr = SP_INIT;
    bus.in_rd_regno = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    bus.in_rd_regno[0] = 5'd2;
    #1;
    chk("sp_after_reset", bus.out_rd_value[0], SP_INIT);
    chk("count_after_reset", 64'(bus.out_busy_count), 64'd0);
    chk("hazard_after_reset", 64'(bus.out_hazard), 64'd0);
    for (int i = 1; i < 32; i++) begin
      bus.in_rd_regno[1] = 5'(i);
      #1;
      chk($sformatf("reg%0d_after_reset", i), bus.out_rd_value[1], (i == 2) ? SP_INIT : 64'd0);
    end

    // Write-to-read bypass on x5
    bus.in_rd_regno[1] = 5'd5;
    bus.in_wr_enable   = 2'b01;
    bus.in_wr_regno[0] = 5'd5;
    bus.in_wr_value[0] = 64'd42;
    #1;
    chk("x5_bypass", bus.out_rd_value[1], 64'd42);
    tick();
    idle();
    #1;
    chk("x5_array", bus.out_rd_value[1], 64'd42);

    // Both ports target x7: port 1 wins
    bus.in_rd_regno[0] = 5'd7;
    bus.in_wr_enable   = 2'b11;
    bus.in_wr_regno[0] = 5'd7;
    bus.in_wr_value[0] = 64'd1;
    bus.in_wr_regno[1] = 5'd7;
    bus.in_wr_value[1] = 64'd2;
    #1;
    chk("x7_bypass_prio", bus.out_rd_value[0], 64'd2);
    tick();
    idle();
    bus.in_rd_regno[1] = 5'd0;
    bus.in_wr_enable   = 2'b01;
    bus.in_wr_regno[0] = 5'd0;
    bus.in_wr_value[0] = 64'd99;
    #1;
    chk("x7_array_prio", bus.out_rd_value[0], 64'd2);
    chk("x0_write_bypass", bus.out_rd_value[1], 64'd0);
    tick();
    idle();
    #1;
    chk("x0_write_array", bus.out_rd_value[1], 64'd0);

    // Issue x9 then write it back
    bus.in_issue_valid = 1'b1;
    bus.in_issue_regno = 5'd9;
    tick();
    idle();
    bus.in_rd_regno[0] = 5'd9;
    #1;
    chk("x9_busy", 64'(bus.out_rd_busy[0]), 64'd1);
    chk("x9_hazard", 64'(bus.out_hazard), 64'd1);
    chk("x9_count", 64'(bus.out_busy_count), 64'd1);
    bus.in_wr_enable   = 2'b01;
    bus.in_wr_regno[0] = 5'd9;
    bus.in_wr_value[0] = 64'd7;
    #1;
    chk("x9_wb_busy", 64'(bus.out_rd_busy[0]), 64'd0);
    chk("x9_wb_hazard", 64'(bus.out_hazard), 64'd0);
    chk("x9_wb_value", bus.out_rd_value[0], 64'd7);
    tick();
    idle();
    #1;
    chk("x9_wb_count", 64'(bus.out_busy_count), 64'd0);

    // Issue and writeback on x9 in the same cycle: set wins
    bus.in_issue_valid = 1'b1;
    bus.in_issue_regno = 5'd9;
    tick();
    idle();
    #1;
    chk("x9_reissue_count", 64'(bus.out_busy_count), 64'd1);
    bus.in_issue_valid = 1'b1;
    bus.in_issue_regno = 5'd9;
    bus.in_wr_enable   = 2'b10;
    bus.in_wr_regno[1] = 5'd9;
    bus.in_wr_value[1] = 64'd55;
    #1;
    chk("x9_same_cycle_busy_pre", 64'(bus.out_rd_busy[0]), 64'd0);
    tick();
    idle();
    #1;
    chk("x9_same_cycle_busy", 64'(bus.out_rd_busy[0]), 64'd1);
    chk("x9_same_cycle_value", bus.out_rd_value[0], 64'd55);
    chk("x9_same_cycle_count", 64'(bus.out_busy_count), 64'd1);

    // Issue x3, x4, x6 with an a0 write alongside; out_args has no bypass
    bus.in_issue_valid = 1'b1;
    bus.in_issue_regno = 5'd3;
    bus.in_wr_enable   = 2'b01;
    bus.in_wr_regno[0] = 5'd10;
    bus.in_wr_value[0] = 64'h1234;
    #1;
    chk("a0_no_bypass", bus.out_args[0], 64'd0);
    tick();
    bus.in_wr_enable   = '0;
    bus.in_issue_regno = 5'd4;
    tick();
    bus.in_issue_regno = 5'd6;
    tick();
    idle();
    #1;
    chk("a0_array", bus.out_args[0], 64'h1234);
    chk("count_four", 64'(bus.out_busy_count), 64'd4);

    // Mid-stream reset, with a write that reset must override
    reset = 1'b1;
    bus.in_issue_valid = 1'b1;
    bus.in_issue_regno = 5'd8;
    bus.in_wr_enable   = 2'b01;
    bus.in_wr_regno[0] = 5'd11;
    bus.in_wr_value[0] = 64'hDEAD;
    tick();
    reset = 1'b0;
    idle();
    bus.in_rd_regno[0] = 5'd3;
    bus.in_rd_regno[1] = 5'd2;
    #1;
    chk("rst_count", 64'(bus.out_busy_count), 64'd0);
    chk("rst_busy_x3", 64'(bus.out_rd_busy[0]), 64'd0);
    chk("rst_hazard", 64'(bus.out_hazard), 64'd0);
    chk("rst_sp", bus.out_rd_value[1], SP_INIT);
    for (int a = 0; a < 8; a++) begin
      chk($sformatf("rst_arg%0d", a), bus.out_args[a], 64'd0);
    end
    bus.in_rd_regno[0] = 5'd8;
    bus.in_rd_regno[1] = 5'd5;
    #1;
    chk("rst_busy_x8", 64'(bus.out_rd_busy[0]), 64'd0);
    chk("rst_x5", bus.out_rd_value[1], 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
